// File: rtl/fpu_pkg.sv
// fpu_pkg: FP16 field constants, multiplier latency and the sequencer state type
package fpu_pkg;
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 10;
  localparam int MAN_MSB = 9;
  localparam int MAN_LSB = 0;
  localparam int MUL_LATENCY = 8;
  typedef enum logic [2:0] {DRAIN, IDLE, WAIT, CAPT, HOLD} seq_state_e;
endpackage

// File: rtl/op_fifo.sv
// op_fifo: operand FIFO with registered ready and no push-through-full
//   push/wdata : write request, taken only when ready=1
//   pop/rdata  : read request and combinational head, ignored when empty
//   empty      : no entries
//   ready      : registered !full, 0 while in reset
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ready_q, ready_d, wr_en, rd_en;
  assign wr_en = push && ready_q;
  assign rd_en = pop && !empty;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign ready = ready_q;
  // ready follows the post-update occupancy, so a pop never opens a slot in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: queues FP16 operand pairs and sequences them one at a time through an external 8-edge multiplier
//   in_valid/in_ready/in_a/in_b/in_tag : operand pair input (in_ready registered, = !full)
//   mul_clk_en/mul_dataa/mul_datab      : one-cycle start pulse and operands to the multiplier
//   mul_result/mul_nan/mul_overflow/mul_underflow : multiplier product and status
//   out_valid/out_ready/out_data/out_tag/out_flags : registered result with {nan, overflow, underflow}
module mult_sequencer
  import fpu_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_clk_en,
  output logic [15:0]      mul_dataa,
  output logic [15:0]      mul_datab,
  input  logic [15:0]      mul_result,
  input  logic             mul_overflow,
  input  logic             mul_underflow,
  input  logic             mul_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
);
  localparam int WIDTH = 32 + TAG_W;
  localparam int CW = $clog2(MUL_LATENCY);
  seq_state_e state_q, state_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d, wait_cnt_q, wait_cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic [15:0] out_data_q, out_data_d;
  logic [2:0] out_flags_q, out_flags_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] head;
  logic empty, issue;
  op_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .wdata({in_tag, in_a, in_b}),
    .pop(issue),
    .rdata(head),
    .empty(empty),
    .ready(in_ready)
  );
  assign issue = (state_q == IDLE) && !empty;
  assign mul_clk_en = issue;
  assign mul_dataa = issue ? head[31:16] : '0;
  assign mul_datab = issue ? head[15:0] : '0;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_tag = out_tag_q;
  assign out_flags = out_flags_q;
  // WAIT spans MUL_LATENCY-1 cycles so CAPT samples the product on the multiplier's 8th edge
  always_comb begin
    state_d = state_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d = wait_cnt_q;
    tag_d = tag_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_tag_d = out_tag_q;
    out_flags_d = out_flags_q;
    case (state_q)
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        state_d = (drain_cnt_q == CW'(MUL_LATENCY - 1)) ? IDLE : DRAIN;
      end
      IDLE: if (!empty) begin
        tag_d = head[WIDTH-1:32];
        wait_cnt_d = CW'(MUL_LATENCY - 2);
        state_d = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        state_d = (wait_cnt_q == '0) ? CAPT : WAIT;
      end
      CAPT: begin
        out_data_d = mul_result;
        out_flags_d = {mul_nan, mul_overflow, mul_underflow};
        out_tag_d = tag_q;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRAIN;
      drain_cnt_q <= '0;
      wait_cnt_q <= '0;
      tag_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q <= '0;
      out_flags_q <= '0;
    end else begin
      state_q <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tag_q <= tag_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_tag_q <= out_tag_d;
      out_flags_q <= out_flags_d;
    end
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: self-checking bench with an FP16 multiplier model and a push-order scoreboard
module tb_mult_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic [7:0] in_tag = '0;
  logic mul_clk_en;
  logic [15:0] mul_dataa, mul_datab, mul_result;
  logic mul_overflow, mul_underflow, mul_nan;
  logic out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0] out_tag;
  logic [2:0] out_flags;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [2:0] flags; logic [15:0] data; logic [7:0] tag;} exp_t;
  exp_t exp_q[$];
  logic [18:0] pipe [8];

  always #5 clk = ~clk;

  mult_sequencer #(.TAG_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_clk_en(mul_clk_en), .mul_dataa(mul_dataa), .mul_datab(mul_datab),
    .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_underflow(mul_underflow), .mul_nan(mul_nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_flags(out_flags)
  );

  // FP16 product with round-to-nearest-even; subnormals flush to zero. Returns {nan, ovf, unf, result}.
  function automatic logic [18:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s, g, st;
    int ea, eb, e;
    logic [21:0] p;
    logic [10:0] m;
    s = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0) ||
        (ea == 31 && b[14:0] == 0) || (eb == 31 && a[14:0] == 0)) return {3'b100, 16'h7E00};
    if (ea == 31 || eb == 31) return {3'b000, s, 5'h1F, 10'h0};
    if (ea == 0 || eb == 0) return {3'b000, s, 15'h0};
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = ea + eb - 15;
    if (p[21]) begin
      m = {1'b0, p[20:11]}; g = p[10]; st = |p[9:0]; e++;
    end else begin
      m = {1'b0, p[19:10]}; g = p[9]; st = |p[8:0];
    end
    if (g && (st || m[0])) m = m + 11'd1;
    if (m[10]) begin m = '0; e++; end
    if (e >= 31) return {3'b010, s, 5'h1F, 10'h0};
    if (e <= 0) return {3'b001, s, 15'h0};
    return {3'b000, s, 5'(e), m[9:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 7) != 0) v[14:10] = 5'($urandom_range(8, 22));
    return v;
  endfunction

  // free-running 8-stage multiplier: sampled on the issue edge, product valid after 7 more edges
  always @(posedge clk) begin
    pipe[0] <= fp16_mul(mul_dataa, mul_datab);
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign {mul_nan, mul_overflow, mul_underflow, mul_result} = pipe[7];

  // scoreboard: every accepted pair, in push order
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back({fp16_mul(in_a, in_b), in_tag});
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag,
                         input bit fixed, input logic [18:0] fx, input string nm);
    int ik, dk, pulses;
    exp_t e;
    @(posedge clk);
    #1 out_ready = 1'b1; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (mul_clk_en !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s push_cycle: mul_clk_en=%b in_ready=%b, required 0 and 1", nm, mul_clk_en, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    ik = -1; dk = -1; pulses = 0;
    for (int k = 1; k <= 40 && dk < 0; k++) begin
      @(negedge clk);
      if (mul_clk_en) begin
        pulses++; ik = k;
        checks++;
        if (mul_dataa !== a || mul_datab !== b) begin
          errors++;
          $display("FAIL %s operands: got %h*%h, required %h*%h", nm, mul_dataa, mul_datab, a, b);
        end
      end
      if (out_valid) dk = k;
    end
    checks++;
    if (ik != 1 || dk != 10 || pulses != 1) begin
      errors++;
      $display("FAIL %s timing: issue at %0d, out_valid at %0d, pulses %0d; required 1, 10, 1", nm, ik, dk, pulses);
    end
    if (dk > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_flags, out_data, out_tag} !== {e.flags, e.data, e.tag}) begin
        errors++;
        $display("FAIL %s result: got flags=%b data=%h tag=%h, required flags=%b data=%h tag=%h",
                 nm, out_flags, out_data, out_tag, e.flags, e.data, e.tag);
      end
      if (fixed) begin
        checks++;
        if ({out_flags, out_data} !== fx || out_tag !== tag) begin
          errors++;
          $display("FAIL %s known_value: got flags=%b data=%h tag=%h, required flags=%b data=%h tag=%h",
                   nm, out_flags, out_data, out_tag, fx[18:16], fx[15:0], tag);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s consume: out_valid=%b after handshake, required 0", nm, out_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mul_clk_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b mul_clk_en=%b out_valid=%b, required 0 0 0", in_ready, mul_clk_en, out_valid);
    end
    checks++;
    if (out_data !== 16'h0 || out_tag !== 8'h0 || out_flags !== 3'b0) begin
      errors++;
      $display("FAIL reset_data: out_data=%h out_tag=%h out_flags=%b, required 0 0 0", out_data, out_tag, out_flags);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_single();
    run_one(16'h3C00, 16'h4000, 8'h11, 1'b1, {3'b000, 16'h4000}, "single");
  endtask

  task automatic test_sign();
    run_one(16'h4200, 16'hC000, 8'h12, 1'b1, {3'b000, 16'hC600}, "sign");
  endtask

  task automatic test_flags();
    logic [15:0] ta [4] = '{16'h7C01, 16'h7800, 16'h0400, 16'hBC00};
    logic [15:0] tb [4] = '{16'h3C00, 16'h7800, 16'h0400, 16'h7C00};
    logic [18:0] tr [4] = '{{3'b100, 16'h7E00}, {3'b010, 16'h7C00}, {3'b001, 16'h0000}, {3'b000, 16'hFC00}};
    for (int i = 0; i < 4; i++) run_one(ta[i], tb[i], 8'(8'h20 + i), 1'b1, tr[i], "flags");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_one(rand_op(), rand_op(), 8'($urandom), 1'b0, '0, "random");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra [6], rb [6], d0;
    logic [7:0] t0;
    logic rdy;
    int idx, n, bad, got, popchk;
    exp_t e;
    for (int i = 0; i < 6; i++) begin ra[i] = rand_op(); rb[i] = rand_op(); end
    @(posedge clk);
    #1 out_ready = 1'b0; idx = 0;
    in_a = ra[0]; in_b = rb[0]; in_tag = 8'd0; in_valid = 1'b1;
    for (n = 0; n < 20 && idx < 5; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin idx++; in_a = ra[idx]; in_b = rb[idx]; in_tag = 8'(idx); end
    end
    checks++;
    if (idx != 5 || n != 5) begin
      errors++;
      $display("FAIL b2b_accept: accepted %0d in %0d cycles, required 5 in 5", idx, n);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: in_ready=%b with 4 queued and 1 issued, required 0", in_ready);
    end
    bad = 0;
    for (int k = 0; k < 30 && !out_valid; k++) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    checks++;
    if (!out_valid || bad != 0) begin
      errors++;
      $display("FAIL b2b_wait: out_valid=%b, in_ready high %0d cycles while full, required 1 and 0", out_valid, bad);
    end
    d0 = out_data; t0 = out_tag; bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || out_tag !== t0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || t0 !== 8'd0) begin
      errors++;
      $display("FAIL b2b_hold: %0d unstable cycles, tag %h, required 0 and 00", bad, t0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    got = 0; popchk = 0;
    for (int k = 0; k < 200 && got < 6; k++) begin
      @(negedge clk);
      if (mul_clk_en && !popchk) begin
        popchk = 1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL push_through_full: in_ready=%b in pop cycle of a full FIFO, required 0", in_ready);
        end
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_order: unexpected result tag=%h, required none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_flags, out_data, out_tag} !== {e.flags, e.data, e.tag} || out_tag !== 8'(got)) begin
            errors++;
            $display("FAIL b2b_order: got flags=%b data=%h tag=%h, required flags=%b data=%h tag=%h",
                     out_flags, out_data, out_tag, e.flags, e.data, 8'(got));
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    checks++;
    if (got != 6 || exp_q.size() != 0 || bad != 0) begin
      errors++;
      $display("FAIL b2b_count: %0d results, %0d left, %0d extra, required 6 0 0", got, exp_q.size(), bad);
    end
  endtask

  task automatic test_drain();
    int ik, dk;
    exp_t e;
    do_reset();
    @(posedge clk);
    #1 in_a = 16'h3C00; in_b = 16'h3C00; in_tag = 8'h33; in_valid = 1'b1; out_ready = 1'b1;
    ik = -1; dk = -1;
    for (int k = 1; k <= 40 && dk < 0; k++) begin
      @(negedge clk);
      if (mul_clk_en && ik < 0) ik = k;
      if (out_valid) dk = k;
      if (k == 1) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    checks++;
    if (ik < 8 || ik > 9 || dk != ik + 9) begin
      errors++;
      $display("FAIL drain: issue at %0d, out_valid at %0d after release, required issue 8..9 and out_valid 9 later", ik, dk);
    end
    checks++;
    if (dk < 0 || exp_q.size() != 1 || out_data !== 16'h3C00 || out_tag !== 8'h33 || out_flags !== 3'b0) begin
      errors++;
      $display("FAIL drain_result: data=%h tag=%h flags=%b queued=%0d, required 3c00 33 000 1",
               out_data, out_tag, out_flags, exp_q.size());
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int bad_v, bad_i;
    @(posedge clk);
    #1 out_ready = 1'b1; in_a = 16'h4000; in_b = 16'h4000; in_tag = 8'h44; in_valid = 1'b1;
    @(posedge clk);
    #1 in_a = 16'h4400; in_b = 16'h3C00; in_tag = 8'h45;
    @(negedge clk);
    checks++;
    if (mul_clk_en !== 1'b1) begin
      errors++;
      $display("FAIL midwait_issue: mul_clk_en=%b, required 1", mul_clk_en);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || mul_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset: out_valid=%b in_ready=%b mul_clk_en=%b, required 0 0 0", out_valid, in_ready, mul_clk_en);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    bad_v = 0; bad_i = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) bad_v++;
      if (mul_clk_en) bad_i++;
    end
    checks++;
    if (bad_v != 0 || bad_i != 0) begin
      errors++;
      $display("FAIL midwait_discard: out_valid cycles %0d, issues %0d, required 0 0", bad_v, bad_i);
    end
    run_one(16'h4200, 16'h4200, 8'h46, 1'b1, {3'b000, 16'h4880}, "after_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_sign();
    test_flags();
    test_random();
    test_back_to_back();
    test_drain();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter TAG_W, default 8, SHALL set the width of the operand-pair tag carried alongside each operation.
REQ-002 Parameter DEPTH, default 4, power of two, SHALL set the number of operand-FIFO entries.
REQ-003 clock  in  1  the single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  an operand pair is offered.
REQ-006 in_ready  out  1  the FIFO can accept the pair (registered, equals !full).
REQ-007 in_a, in_b  in  16 each  FP16 operands.
REQ-008 in_tag  in  TAG_W  opaque tag returned with the result.
REQ-009 mul_clk_en  out  1  start pulse to the FP16 multiplier.
REQ-010 mul_dataa, mul_datab  out  16 each  operands to the multiplier, valid while mul_clk_en=1.
REQ-011 mul_result  in  16  multiplier product.
REQ-012 mul_overflow, mul_underflow, mul_nan  in  1 each  multiplier status flags.
REQ-013 out_valid  out  1  result register holds an unconsumed result.
REQ-014 out_ready  in  1  the consumer accepts the result.
REQ-015 out_data  out  16  captured product.
REQ-016 out_tag  out  TAG_W  tag of that product.
REQ-017 out_flags  out  3  captured {nan, overflow, underflow}.

Function
REQ-018 The FIFO SHALL push on in_valid&&in_ready; when full, in_ready SHALL be 0 even in a cycle that pops (no push-through-full).
REQ-019 A pair pushed into an empty FIFO SHALL NOT be issued in the same cycle (no bypass); the earliest issue is the next cycle.
REQ-020 The FSM SHALL have the states DRAIN, IDLE, WAIT, CAPT, HOLD.
REQ-021 DRAIN SHALL count MUL_LATENCY (8) cycles, then go to IDLE; no issue SHALL occur in DRAIN, though the FIFO still accepts pushes.
REQ-022 In IDLE with the FIFO non-empty, the block SHALL assert mul_clk_en for exactly one cycle with mul_dataa/mul_datab = FIFO head, pop the head, latch its tag, load wait_cnt=6, and go to WAIT.
REQ-023 mul_clk_en SHALL be 0 in every state other than the IDLE issue cycle; mul_dataa/mul_datab SHALL be 0 when not issuing.
REQ-024 WAIT SHALL decrement wait_cnt each cycle and go to CAPT on the edge where wait_cnt==0 (7 cycles in WAIT, so the issue edge plus 7 further edges = 8 edges, matching the multiplier's 8-edge latency).
REQ-025 CAPT SHALL last one cycle and register out_data=mul_result, out_flags={mul_nan,mul_overflow,mul_underflow} and out_tag, set out_valid=1, and go to HOLD.
REQ-026 HOLD SHALL keep out_data/out_tag/out_flags stable while out_valid&&!out_ready, and on out_valid&&out_ready SHALL clear out_valid and go to IDLE.
REQ-027 Issue-to-out_valid latency SHALL be 9 cycles; minimum issue interval SHALL be 10 cycles with out_ready held at 1.
REQ-028 FIFO read/write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ with equal low bits, empty = pointers equal.
REQ-029 Results SHALL emerge in push order with tags unmodified.

Reset
REQ-030 Reset SHALL force: state=DRAIN, drain_cnt=0, FIFO empty, in_ready=0 during reset and 1 the cycle after release, mul_clk_en=0, out_valid=0, out_data=0, out_tag=0, out_flags=0.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight operation and the FIFO contents with no out_valid; DRAIN then guarantees the unreset multiplier has returned to IDLE before the next issue.

Structure
REQ-032 Package fpu_pkg SHALL hold the FP16 field constants (SIGN_BIT=15, EXP 14:10, MAN 9:0), MUL_LATENCY=8 and the sequencer state enum.
REQ-033 The FIFO SHALL be the sub-module op_fifo (parameters DEPTH and WIDTH=32+TAG_W); the multiplier SHALL remain external.

Verification (bench connects the FP16 multiplier)
REQ-034 Single op: push 0x3C00*0x4000, tag 0x11 -> mul_clk_en pulses once; out_valid rises 9 cycles later with out_data=0x4000, out_tag=0x11, out_flags=0.
REQ-035 Sign case: push 0x4200*0xC000 -> out_data=0xC600.
REQ-036 Back-pressure: push 5 pairs back-to-back with out_ready=0 -> in_ready falls after 4 accepted plus 1 issued; out_data is stable through HOLD; release out_ready -> all 5 results arrive in order with tags 0..4.
REQ-037 Post-reset drain: push one pair on the first cycle after reset release -> mul_clk_en does not assert before drain completes (8 DRAIN cycles); the result is correct.
REQ-038 Reset mid-WAIT: assert reset 3 cycles after issue -> no out_valid; FIFO empty; the next pushed pair completes with the correct result.
REQ-039 Simultaneous events: push while full and out handshake coincide -> no push accepted; pointers wrap across a 2*DEPTH boundary with no lost or duplicated entries.
